// File: rtl/inst_enc_pkg.sv
// Op enum, opcode/funct constants and word-packing helpers for inst_encoder_writer.
// INST_ENC_LI_EXPAND_EN adds the LI_LO state used by the two-word LI expansion.
package inst_enc_pkg;

    typedef enum logic [5:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_JR,
        OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_LUI,
        OP_LWC1, OP_SWC1, OP_J, OP_JAL,
        OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV, OP_FSQRT,
        OP_MFC0, OP_MTC0, OP_ERET, OP_SYSCALL, OP_NOP, OP_LI
    } op_e;

`ifdef INST_ENC_LI_EXPAND_EN
    typedef enum logic {ST_IDLE, ST_LI_LO} state_e;
`else
    typedef enum logic {ST_IDLE} state_e;
`endif

    localparam logic [5:0] OPC_SPECIAL = 6'b000000;
    localparam logic [5:0] OPC_ADDI    = 6'b001000;
    localparam logic [5:0] OPC_ANDI    = 6'b001100;
    localparam logic [5:0] OPC_ORI     = 6'b001101;
    localparam logic [5:0] OPC_XORI    = 6'b001110;
    localparam logic [5:0] OPC_LW      = 6'b100011;
    localparam logic [5:0] OPC_SW      = 6'b101011;
    localparam logic [5:0] OPC_BEQ     = 6'b000100;
    localparam logic [5:0] OPC_BNE     = 6'b000101;
    localparam logic [5:0] OPC_LUI     = 6'b001111;
    localparam logic [5:0] OPC_LWC1    = 6'b110001;
    localparam logic [5:0] OPC_SWC1    = 6'b111001;
    localparam logic [5:0] OPC_J       = 6'b000010;
    localparam logic [5:0] OPC_JAL     = 6'b000011;
    localparam logic [5:0] OPC_COP1    = 6'b010001;
    localparam logic [5:0] OPC_COP0    = 6'b010000;

    localparam logic [5:0] FN_ADD     = 6'b100000;
    localparam logic [5:0] FN_SUB     = 6'b100010;
    localparam logic [5:0] FN_AND     = 6'b100100;
    localparam logic [5:0] FN_OR      = 6'b100101;
    localparam logic [5:0] FN_XOR     = 6'b100110;
    localparam logic [5:0] FN_SLL     = 6'b000000;
    localparam logic [5:0] FN_SRL     = 6'b000010;
    localparam logic [5:0] FN_SRA     = 6'b000011;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;
    localparam logic [5:0] FN_ERET    = 6'b011000;

    localparam logic [4:0] FPU_FMT = 5'b10000;
    localparam logic [4:0] CP0_MF  = 5'b00000;
    localparam logic [4:0] CP0_MT  = 5'b00100;
    localparam logic [4:0] CP0_CO  = 5'b10000;

    function automatic logic [31:0] r_word(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                           logic [4:0] sa, logic [5:0] fn);
        return {OPC_SPECIAL, rs, rt, rd, sa, fn};
    endfunction

    function automatic logic [31:0] i_word(logic [5:0] opc, logic [4:0] rs, logic [4:0] rt,
                                           logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/inst_field_encoder.sv
// Combinational packer: op enum + fields -> 32-bit instruction word and legality flag.
// Fields an op does not use are forced to zero so every word round-trips through the predecoder.
module inst_field_encoder
    import inst_enc_pkg::*;
(
    input  logic [5:0]  op_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  sa_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] addr_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    always_comb begin
        word_o  = '0;
        legal_o = 1'b1;
        case (op_i)
            OP_ADD:     word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_ADD);
            OP_SUB:     word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_SUB);
            OP_AND:     word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_AND);
            OP_OR:      word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_OR);
            OP_XOR:     word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_XOR);
            OP_SLL:     word_o = r_word(5'd0, rt_i, rd_i, sa_i, FN_SLL);
            OP_SRL:     word_o = r_word(5'd0, rt_i, rd_i, sa_i, FN_SRL);
            OP_SRA:     word_o = r_word(5'd0, rt_i, rd_i, sa_i, FN_SRA);
            OP_JR:      word_o = r_word(rs_i, 5'd0, 5'd0, 5'd0, FN_JR);
            OP_SYSCALL: word_o = r_word(5'd0, 5'd0, 5'd0, 5'd0, FN_SYSCALL);
            OP_ADDI:    word_o = i_word(OPC_ADDI, rs_i, rt_i, imm_i);
            OP_ANDI:    word_o = i_word(OPC_ANDI, rs_i, rt_i, imm_i);
            OP_ORI:     word_o = i_word(OPC_ORI,  rs_i, rt_i, imm_i);
            OP_XORI:    word_o = i_word(OPC_XORI, rs_i, rt_i, imm_i);
            OP_LW:      word_o = i_word(OPC_LW,   rs_i, rt_i, imm_i);
            OP_SW:      word_o = i_word(OPC_SW,   rs_i, rt_i, imm_i);
            OP_BEQ:     word_o = i_word(OPC_BEQ,  rs_i, rt_i, imm_i);
            OP_BNE:     word_o = i_word(OPC_BNE,  rs_i, rt_i, imm_i);
            OP_LUI:     word_o = i_word(OPC_LUI,  5'd0, rt_i, imm_i);
            OP_LWC1:    word_o = i_word(OPC_LWC1, rs_i, rt_i, imm_i);
            OP_SWC1:    word_o = i_word(OPC_SWC1, rs_i, rt_i, imm_i);
            OP_J:       word_o = {OPC_J, addr_i};
            OP_JAL:     word_o = {OPC_JAL, addr_i};
            OP_FADD:    word_o = {OPC_COP1, FPU_FMT, rt_i, rd_i, sa_i, 6'd0};
            OP_FSUB:    word_o = {OPC_COP1, FPU_FMT, rt_i, rd_i, sa_i, 6'd1};
            OP_FMUL:    word_o = {OPC_COP1, FPU_FMT, rt_i, rd_i, sa_i, 6'd2};
            OP_FDIV:    word_o = {OPC_COP1, FPU_FMT, rt_i, rd_i, sa_i, 6'd3};
            OP_FSQRT:   word_o = {OPC_COP1, FPU_FMT, 5'd0, rd_i, sa_i, 6'd4};
            OP_MFC0:    word_o = {OPC_COP0, CP0_MF, rt_i, rd_i, 11'd0};
            OP_MTC0:    word_o = {OPC_COP0, CP0_MT, rt_i, rd_i, 11'd0};
            OP_ERET:    word_o = {OPC_COP0, CP0_CO, 15'd0, FN_ERET};
            OP_NOP:     word_o = '0;
            default:    legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/inst_encoder_writer.sv
// Accepts instruction requests, encodes them and writes words sequentially into instruction memory.
// INST_ENC_LI_EXPAND_EN enables op LI, expanded into LUI + ORI over two cycles.
module inst_encoder_writer
    import inst_enc_pkg::*;
#(
    parameter int AW    = 6,
    parameter int DEPTH = 64
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [5:0]    in_op,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_sa,
    input  logic [15:0]   in_imm,
    input  logic [15:0]   in_hi,
    input  logic [25:0]   in_addr,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          err
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    state_e        state_q;
    logic          mem_we_q, err_q;
    logic [AW-1:0] mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic [AW:0]   count_q;
    logic [31:0]   enc_word;
    logic          enc_legal;

`ifdef INST_ENC_LI_EXPAND_EN
    // LI needs two free slots; the ORI half is parked here while in LI_LO.
    localparam logic [AW:0] LI_LAST_C = (AW+1)'(DEPTH - 2);
    logic [31:0] li_lo_q;
`else
    logic unused_hi;
    assign unused_hi = ^in_hi;
`endif

    inst_field_encoder u_enc (
        .op_i    (in_op),
        .rs_i    (in_rs),
        .rt_i    (in_rt),
        .rd_i    (in_rd),
        .sa_i    (in_sa),
        .imm_i   (in_imm),
        .addr_i  (in_addr),
        .word_o  (enc_word),
        .legal_o (enc_legal)
    );

    assign full      = (count_q == DEPTH_C);
    assign in_ready  = (state_q == ST_IDLE) && !full && !clr;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (!clrn || clr) begin
            state_q     <= ST_IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
`ifdef INST_ENC_LI_EXPAND_EN
            li_lo_q     <= '0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
`ifdef INST_ENC_LI_EXPAND_EN
                        if (in_op == OP_LI) begin
                            if (count_q <= LI_LAST_C) begin
                                mem_we_q    <= 1'b1;
                                mem_addr_q  <= count_q[AW-1:0];
                                mem_wdata_q <= i_word(OPC_LUI, 5'd0, in_rt, in_hi);
                                count_q     <= count_q + ONE_C;
                                li_lo_q     <= i_word(OPC_ORI, in_rt, in_rt, in_imm);
                                state_q     <= ST_LI_LO;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end else
`endif
                        if (enc_legal) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= count_q[AW-1:0];
                            mem_wdata_q <= enc_word;
                            count_q     <= count_q + ONE_C;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
`ifdef INST_ENC_LI_EXPAND_EN
                ST_LI_LO: begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= count_q[AW-1:0];
                    mem_wdata_q <= li_lo_q;
                    count_q     <= count_q + ONE_C;
                    state_q     <= ST_IDLE;
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_encoder_writer.sv
// Directed + randomized bench for inst_encoder_writer against a table-driven behavioural model.
// Honours INST_ENC_LI_EXPAND_EN for the LI expectations.
module tb_inst_encoder_writer;
    import inst_enc_pkg::*;

    localparam int AW    = 6;
    localparam int DEPTH = 64;
`ifdef INST_ENC_LI_EXPAND_EN
    localparam bit LI_EN = 1'b1;
`else
    localparam bit LI_EN = 1'b0;
`endif

    // Reference tables straight from the encoding rules
    localparam int unsigned RFN[9]  = '{32, 34, 36, 37, 38, 0, 2, 3, 8};
    localparam int unsigned IOPC[11] = '{8, 12, 13, 14, 35, 43, 4, 5, 15, 49, 57};

    logic          clk, clrn, clr, in_valid, in_ready;
    logic [5:0]    in_op;
    logic [4:0]    in_rs, in_rt, in_rd, in_sa;
    logic [15:0]   in_imm, in_hi;
    logic [25:0]   in_addr;
    logic          mem_we, full, err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   count;

    int checks = 0;
    int errors = 0;

    int          m_cnt;
    bit          m_we, m_err, m_pend;
    int          m_addr;
    logic [31:0] m_data, m_lo;

    inst_encoder_writer #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .clrn(clrn), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_sa(in_sa),
        .in_imm(in_imm), .in_hi(in_hi), .in_addr(in_addr),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .full(full), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] ref_enc(int op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                            logic [4:0] sa, logic [15:0] imm, logic [25:0] a);
        logic [31:0] w;
        bit ok;
        w  = 32'd0;
        ok = 1'b1;
        if (op <= 8) begin
            w = RFN[op];
            if (!(op >= 5 && op <= 7)) w = w | (32'(rs) << 21);
            if (op != 8) w = w | (32'(rt) << 16) | (32'(rd) << 11);
            if (op >= 5 && op <= 7) w = w | (32'(sa) << 6);
        end else if (op <= 19) begin
            w = (IOPC[op-9] << 26) | (32'(rt) << 16) | 32'(imm);
            if (op != 17) w = w | (32'(rs) << 21);
        end else if (op <= 21) begin
            w = (32'(op - 18) << 26) | 32'(a);
        end else if (op <= 26) begin
            w = (32'd17 << 26) | (32'd16 << 21) | (32'(rd) << 11) | (32'(sa) << 6) | 32'(op - 22);
            if (op != 26) w = w | (32'(rt) << 16);
        end else if (op == 27 || op == 28) begin
            w = (32'd16 << 26) | (32'(rt) << 16) | (32'(rd) << 11);
            if (op == 28) w = w | (32'd4 << 21);
        end else if (op == 29) begin
            w = (32'd16 << 26) | (32'd16 << 21) | 32'd24;
        end else if (op == 30) begin
            w = 32'd12;
        end else if (op == 31) begin
            w = 32'd0;
        end else begin
            ok = 1'b0;
        end
        return {ok, w};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v, input int op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm,
                        input logic [15:0] hi, input logic [25:0] a, input bit c, input bit rn);
        bit rdy, acc;
        logic [32:0] e;
        in_valid = v; in_op = 6'(op); in_rs = rs; in_rt = rt; in_rd = rd; in_sa = sa;
        in_imm = imm; in_hi = hi; in_addr = a; clr = c; clrn = rn;
        rdy = !m_pend && (m_cnt < DEPTH) && !c;
        acc = v && rdy && rn;
        #1;
        if (rn) chk("in_ready", 32'(in_ready), 32'(rdy));
        m_we  = 1'b0;
        m_err = 1'b0;
        if (!rn || c) begin
            m_cnt = 0; m_addr = 0; m_data = 32'd0; m_pend = 1'b0;
        end else if (m_pend) begin
            m_we = 1'b1; m_addr = m_cnt; m_data = m_lo; m_cnt++; m_pend = 1'b0;
        end else if (acc) begin
            if (op == 32 && LI_EN) begin
                if (DEPTH - m_cnt >= 2) begin
                    m_we = 1'b1; m_addr = m_cnt; m_cnt++; m_pend = 1'b1;
                    m_data = (32'd15 << 26) | (32'(rt) << 16) | 32'(hi);
                    m_lo   = (32'd13 << 26) | (32'(rt) << 21) | (32'(rt) << 16) | 32'(imm);
                end else begin
                    m_err = 1'b1;
                end
            end else begin
                e = ref_enc(op, rs, rt, rd, sa, imm, a);
                if (e[32]) begin
                    m_we = 1'b1; m_addr = m_cnt; m_data = e[31:0]; m_cnt++;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("mem_we",    32'(mem_we),    32'(m_we));
        chk("mem_addr",  32'(mem_addr),  32'(m_addr[AW-1:0]));
        chk("mem_wdata", mem_wdata,      m_data);
        chk("count",     32'(count),     32'(m_cnt));
        chk("full",      32'(full),      32'(m_cnt == DEPTH));
        chk("err",       32'(err),       32'(m_err));
    endtask

    task automatic send(input int op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [4:0] sa, input logic [15:0] imm, input logic [15:0] hi,
                        input logic [25:0] a);
        step(1'b1, op, rs, rt, rd, sa, imm, hi, a, 1'b0, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 16'd0, 26'd0, 1'b0, 1'b1);
    endtask

    task automatic send_rand_legal();
        send(int'($urandom_range(0, 31)), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             16'($urandom), 16'($urandom), 26'($urandom));
    endtask

    initial begin
        m_cnt = 0; m_we = 0; m_err = 0; m_pend = 0; m_addr = 0; m_data = 0; m_lo = 0;

        // 1: reset, single ADD
        step(1'b0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 16'd0, 26'd0, 1'b0, 1'b0);
        step(1'b1, 0, 5'd1, 5'd1, 5'd1, 5'd1, 16'd1, 16'd1, 26'd1, 1'b0, 1'b0);
        send(int'(OP_ADD), 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 16'd0, 26'd0);
        chk("t1_add_word", mem_wdata, 32'h00221820);
        idle();

        // 2: back-to-back ADDI / LW / J after clr
        step(1'b0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 16'd0, 26'd0, 1'b1, 1'b1);
        send(int'(OP_ADDI), 5'd0, 5'd8, 5'd0, 5'd0, 16'hFFFF, 16'd0, 26'd0);
        chk("t2_addi_word", mem_wdata, 32'h2008FFFF);
        send(int'(OP_LW), 5'd8, 5'd9, 5'd0, 5'd0, 16'h0004, 16'd0, 26'd0);
        chk("t2_lw_word", mem_wdata, 32'h8D090004);
        send(int'(OP_J), 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 16'd0, 26'h0000040);
        chk("t2_j_word", mem_wdata, 32'h08000040);
        chk("t2_j_addr", 32'(mem_addr), 32'd2);

        // 3: FPU / CP0 / NOP and an out-of-range op
        send(int'(OP_FADD), 5'd0, 5'd1, 5'd2, 5'd2, 16'd0, 16'd0, 26'd0);
        chk("t3_fadd_word", mem_wdata, 32'h46011080);
        send(int'(OP_ERET), 5'd3, 5'd3, 5'd3, 5'd3, 16'h3, 16'h3, 26'h3);
        chk("t3_eret_word", mem_wdata, 32'h42000018);
        send(int'(OP_NOP), 5'd7, 5'd7, 5'd7, 5'd7, 16'h7, 16'h7, 26'h7);
        send(40, 5'd1, 5'd1, 5'd1, 5'd1, 16'd1, 16'd1, 26'd1);
        idle();

        // 5: LI expansion (illegal when expansion is not built)
        send(int'(OP_LI), 5'd0, 5'd5, 5'd0, 5'd0, 16'h5678, 16'h1234, 26'd0);
        if (LI_EN) chk("t5_lui_word", mem_wdata, 32'h3C051234);
        send(int'(OP_ADD), 5'd4, 5'd5, 5'd6, 5'd0, 16'd0, 16'd0, 26'd0);
        if (LI_EN) chk("t5_ori_word", mem_wdata, 32'h34A55678);
        idle();

        // randomized traffic including illegal ops and occasional clr
        for (int i = 0; i < 250; i++) begin
            step(($urandom_range(0, 9) != 0), int'($urandom_range(0, 40)),
                 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 16'($urandom), 16'($urandom), 26'($urandom),
                 ($urandom_range(0, 39) == 0), 1'b1);
        end

        // 4: fill, LI with one free slot, full, clr with valid held
        step(1'b0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 16'd0, 26'd0, 1'b1, 1'b1);
        for (int i = 0; i < DEPTH - 1; i++) send_rand_legal();
        send(int'(OP_LI), 5'd0, 5'd5, 5'd0, 5'd0, 16'h5678, 16'h1234, 26'd0);
        chk("t5_li_last_cnt", 32'(count), 32'(DEPTH - 1));
        send_rand_legal();
        chk("t4_full", 32'(full), 32'd1);
        send_rand_legal();
        send_rand_legal();
        step(1'b1, int'(OP_ADD), 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 16'd0, 26'd0, 1'b1, 1'b1);
        chk("t4_clr_count", 32'(count), 32'd0);
        idle();

        // 6: clrn mid-stream, including during LI_LO
        send(int'(OP_ADD), 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 16'd0, 26'd0);
        send(int'(OP_LI), 5'd0, 5'd7, 5'd0, 5'd0, 16'hBEEF, 16'hDEAD, 26'd0);
        step(1'b1, int'(OP_ADD), 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 16'd0, 26'd0, 1'b0, 1'b0);
        chk("t6_rst_wdata", mem_wdata, 32'd0);
        idle();
        send(int'(OP_SRA), 5'd9, 5'd10, 5'd11, 5'd12, 16'd0, 16'd0, 26'd0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
